// File: rtl/buffer_arbiter.sv
// buffer_arbiter: round-robin arbiter that loads one requester's word per
// cycle into a single shared output buffer with a valid/ready handshake.
// Each buffered word is tagged with the index of the requester that sent it.
module buffer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready
);

  logic                r_full;
  logic [DATA_W-1:0]   r_data;
  logic [SRC_W-1:0]    r_src;
  logic [SRC_W-1:0]    r_ptr;

  logic [DATA_W-1:0]   w_words [NUM_REQ];
  logic                w_load_en;
  logic                w_found;
  logic [SRC_W-1:0]    w_win;
  logic [SRC_W-1:0]    w_idx;
  logic [SRC_W-1:0]    w_ptr_next;
  logic [NUM_REQ-1:0]  w_grant;
  logic                w_load;
  int                  w_sum;

  // Split the flat request bus into per-requester words.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign w_words[g] = req_data[g*DATA_W +: DATA_W];
  end

  // The buffer can accept a word when empty or when it drains this cycle.
  assign w_load_en = !r_full || out_ready;

  // Search requesters starting at the priority pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    w_sum   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_idx = SRC_W'(w_sum);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // One-hot grant to the winner, only inside the load window.
  always_comb begin
    w_grant = '0;
    if (w_load_en && w_found) w_grant[w_win] = 1'b1;
  end

  assign w_load     = w_load_en && w_found;
  assign w_ptr_next = (w_win == SRC_W'(NUM_REQ - 1)) ? '0 : w_win + SRC_W'(1);
  // Reset blanks the grant immediately so no word is taken during reset.
  assign req_ready  = reset ? '0 : w_grant;

  // Buffer, tag and priority pointer; pointer advances only on a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_src  <= '0;
      r_ptr  <= '0;
    end else if (w_load) begin
      r_full <= 1'b1;
      r_data <= w_words[w_win];
      r_src  <= w_win;
      r_ptr  <= w_ptr_next;
    end else if (r_full && out_ready) begin
      r_full <= 1'b0;
    end
  end

  assign out_valid = r_full;
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule

// File: doc/buffer_arbiter.md
# buffer_arbiter

Round-robin arbiter that shares a single DATA_W-bit buffer register among NUM_REQ requesters. It presents the buffered word downstream with a valid/ready handshake. It sits between several producer ports and one consumer, and it sequences which producer's word is loaded into the shared buffer on each clock. Each word is tagged with the index of the requester that supplied it.

## Interface

Parameters:

- NUM_REQ, default 4: number of requesters. Must be 2 or more.
- DATA_W, default 4: width of each data word.
- SRC_W, default $clog2(NUM_REQ): width of the source tag. Must be 1 or more.

Ports:

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i set means requester i offers a word.
- req_data  input  NUM_REQ*DATA_W  requester i's word on bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot or zero; bit i set means requester i's word is accepted this cycle.
- out_valid  output  1  buffer holds a word.
- out_data  output  DATA_W  buffered word.
- out_src  output  SRC_W  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts the buffered word.

## Operation

- State: full flag (drives out_valid), data register, source register, round-robin pointer ptr (range 0..NUM_REQ-1).
- Drain: a transfer occurs when out_valid && out_ready.
- Load window: load_en = !out_valid || (out_valid && out_ready).
- Arbitration (combinational):
  - When load_en is high, the winner is the first asserted req_valid bit searching ptr, ptr+1, … and wrapping modulo NUM_REQ.
  - req_ready is high only for the winner.
  - req_ready is all-zero when load_en is low or no req_valid bit is set.
- Load, on the clock edge with a winner:
  - out_data takes the winner's word.
  - out_src takes the winner index.
  - out_valid goes to 1.
  - ptr becomes (winner+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
- Drain without load: out_valid goes to 0. out_data and out_src hold their last values.
- No drain and full: all state holds and req_ready is all-zero (backpressure).
- ptr changes only on a load. Idle cycles do not rotate priority.
- Requester protocol:
  - A requester holds req_valid and req_data stable until it sees req_ready.
  - A requester may drop req_valid before being granted; the arbiter then skips it.
- The consumer may hold out_ready high continuously. out_ready while out_valid is 0 has no effect.
- Reset, asynchronous and allowed at any time including mid-transfer:
  - out_valid=0, out_data=0, out_src=0, ptr=0.
  - req_ready is all-zero while reset is high.
  - A word that was in the buffer is discarded. No partial load survives.

## Timing

- Latency: a word accepted (req_ready high) in cycle T appears on out_valid/out_data in cycle T+1.
- Throughput: one word per cycle when out_ready is held high and requests are pending (simultaneous drain and load).
- req_ready depends combinationally on req_valid, out_valid, out_ready and ptr. There is no combinational path from req_data to any output.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0,… and each requester waits at most NUM_REQ-1 loads.
- Release from reset: the first edge after reset deasserts may load. Requester 0 has top priority initially.

## Test plan

- Reset values: assert reset mid-stream with out_valid=1 → out_valid=0, out_data=0, out_src=0, req_ready=0000 immediately. After release, with all requesters valid, the first grant is requester 0.
- Single requester: req_valid=0100, req_data word2=4'hA, out_ready=1 → req_ready=0100 in cycle T. In T+1, out_valid=1, out_data=4'hA, out_src=2.
- Round-robin: all four valid with data 1,2,3,4 and out_ready=1 → grants 0,1,2,3,0 on consecutive cycles. Outputs 1,2,3,4,1 with out_src 0,1,2,3,0.
- Backpressure: buffer full with 4'h5, out_ready=0 for 3 cycles, requester 1 valid → req_ready=0000 and out_data stays 4'h5. When out_ready=1, requester 1 is granted the same cycle and its word appears next cycle.
- Skip and wrap: ptr=3, req_valid=0010 → requester 1 granted and ptr becomes 2. Then req_valid=1001 → requester 3 granted, then requester 0 (ptr wraps to 0, then 1).
- Drain to empty: one word buffered, no requests, out_ready=1 → out_valid=0 next cycle. out_data holds its value and ptr is unchanged.
